spi_arbiter: RTL and testbench

Shares one spi_controller engine between NREQ independent requesters, such as the Wishbone SPI bridge and hardware pollers. It uses round-robin arbitration and sequences each transfer: grant, start, wait for busy, wait for new_data, return response. It fans the single engine slave-select out to one ss line per requester and bounds every transaction with a watchdog.

---
 rtl/spi_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_controller engine between NREQ requesters.
// Round-robin grant, start/busy/new_data sequencing, per-requester slave
// select fan-out and a watchdog that bounds every transaction.
module spi_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int TMO_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic [2:0]        owner,
    output logic              active,
    output logic              spi_start,
    output logic [DW-1:0]     spi_data_in,
    input  logic [DW-1:0]     spi_data_out,
    input  logic              spi_busy,
    input  logic              spi_new_data,
    input  logic              spi_ss,
    output logic [NREQ-1:0]   ss_o
);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    // Watchdog fires on the cycle the counter would reach its terminal count.
    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'((2 ** TMO_W) - 2);

    state_t            state, state_nxt;
    logic [2:0]        rr;
    logic [TMO_W-1:0]  wd;
    logic              err_q;

    logic              any_req;
    logic [2:0]        winner;
    logic [DW-1:0]     win_data;
    logic              counting;
    logic              tmo_hit;
    logic              cap;

    // Round-robin pick: indices at/above rr outrank the wrapped ones below it;
    // within each group the lowest index is assigned last and therefore wins.
    always_comb begin
        any_req  = 1'b0;
        winner   = rr;
        win_data = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) < rr)) begin
                any_req  = 1'b1;
                winner   = 3'(i);
                win_data = req_data[i*DW +: DW];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) >= rr)) begin
                any_req  = 1'b1;
                winner   = 3'(i);
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    assign counting = (state == START) || (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign tmo_hit  = counting && (wd == WD_LAST);
    assign cap      = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && spi_new_data;

    // Next-state logic; real data wins over a coincident watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (any_req) state_nxt = START;
            START:     state_nxt = tmo_hit ? RESP : WAIT_BUSY;
            WAIT_BUSY: begin
                if (spi_new_data)  state_nxt = RESP;
                else if (spi_busy) state_nxt = WAIT_DONE;
                else if (tmo_hit)  state_nxt = RESP;
            end
            WAIT_DONE: begin
                if (spi_new_data || tmo_hit) state_nxt = RESP;
            end
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State, grant capture, watchdog, response capture and rr pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr          <= '0;
            owner       <= '0;
            wd          <= '0;
            err_q       <= 1'b0;
            rsp_data    <= '0;
            spi_data_in <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner       <= winner;
                spi_data_in <= win_data;
                wd          <= '0;
            end else if (counting) begin
                wd <= wd + 1'b1;
            end
            if (state != RESP && state_nxt == RESP) begin
                err_q    <= ~cap;
                rsp_data <= cap ? spi_data_out : '0;
            end
            if (state == RESP) begin
                rr <= (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;
            end
        end
    end

    // Engine start is held until busy (or new_data) is seen, dropped on timeout.
    assign spi_start = (state == START) || (state == WAIT_BUSY);
    assign active    = (state != IDLE);
    assign rsp_err   = (state == RESP) && err_q;

    // Per-requester decode of ack/response pulses and slave-select fan-out.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_ack[i]   = (state == START) && (owner == 3'(i));
        assign rsp_valid[i] = (state == RESP)  && (owner == 3'(i));
        assign ss_o[i]      = (active && (owner == 3'(i))) ? spi_ss : 1'b1;
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural
// spi_controller model (normal / fast / hung engine).
module tb_spi_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int TMO_W = 4;
    localparam int NORM  = 0;
    localparam int FAST  = 1;
    localparam int HANG  = 2;

    typedef struct {
        int          idx;
        int          md;
        logic [15:0] data;
        int          ack;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic [2:0]          owner;
    logic                active;
    logic                spi_start;
    logic [DW-1:0]       spi_data_in;
    logic [DW-1:0]       spi_data_out;
    logic                spi_busy;
    logic                spi_new_data;
    logic                spi_ss;
    logic [NREQ-1:0]     ss_o;

    logic                m_busy, m_nd, m_prev;
    logic [DW-1:0]       m_dout;
    int                  m_cnt;
    int                  mode;
    logic [NREQ-1:0]     sticky;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   nd_cyc  = 0;
    int   cur     = 0;
    int   gnt_q[$];
    exp_t rsp_q[$];

    spi_arbiter #(.NREQ(NREQ), .DW(DW), .TMO_W(TMO_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .owner(owner), .active(active),
        .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
        .spi_busy(spi_busy), .spi_new_data(spi_new_data), .spi_ss(spi_ss),
        .ss_o(ss_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign spi_busy     = m_busy;
    assign spi_new_data = m_nd;
    assign spi_data_out = m_dout;
    assign spi_ss       = ~m_busy;

    // Engine model: loopback of data_in, 10-cycle busy, fast or hung variants.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_nd <= 1'b0; m_dout <= '0; m_cnt <= 0; m_prev <= 1'b0;
        end else begin
            m_prev <= spi_start;
            if (m_cnt != 0) begin
                if (m_cnt == 1) begin m_busy <= 1'b0; m_nd <= 1'b1; end
                m_cnt <= m_cnt - 1;
            end else begin
                m_busy <= 1'b0;
                m_nd   <= 1'b0;
                if (spi_start && !m_prev) begin
                    if (mode == NORM) begin
                        m_busy <= 1'b1; m_cnt <= 10; m_dout <= spi_data_in;
                    end else if (mode == FAST) begin
                        m_busy <= 1'b1; m_nd <= 1'b1; m_dout <= spi_data_in;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((gnt_q.size() != 0 || rsp_q.size() != 0 || active || req_valid != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", 32'(n < budget), 1);
    endtask

    task automatic wait_ack(input int i, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack[i] && n < budget);
        chk("ack_wait", 32'(req_ack[i]), 1);
    endtask

    // Requesters: drop the level request once acknowledged unless held sticky.
    initial forever begin
        @(negedge clk);
        if (reset_n)
            for (int i = 0; i < NREQ; i++)
                if (req_ack[i] && !sticky[i]) req_valid[i] = 1'b0;
    end

    // Monitor: grant order, captured word, response scoreboard, latency, ss fan-out.
    initial forever begin
        logic [3:0] e4;
        exp_t e;
        int g;
        @(negedge clk);
        if (reset_n) begin
            if (spi_new_data) nd_cyc = cyc;
            if (|req_ack) begin
                chk("ack_1hot", $countones(req_ack), 1);
                if (gnt_q.size() == 0) chk("unexp_ack", 32'(req_ack), 0);
                else begin
                    g = gnt_q.pop_front();
                    e4 = 4'b0001 << g;
                    chk("gnt_order", 32'(req_ack), 32'(e4));
                    chk("owner", 32'(owner), g);
                    chk("data_in", 32'(spi_data_in), 32'(req_data[g*DW +: DW]));
                    cur = g;
                    e.idx = g; e.md = mode; e.ack = cyc;
                    e.data = (mode == HANG) ? 16'h0 : req_data[g*DW +: DW];
                    rsp_q.push_back(e);
                end
            end
            if (|rsp_valid) begin
                chk("rsp_ack_excl", 32'(|req_ack), 0);
                if (rsp_q.size() == 0) chk("unexp_rsp", 32'(rsp_valid), 0);
                else begin
                    e = rsp_q.pop_front();
                    e4 = 4'b0001 << e.idx;
                    chk("rsp_idx", 32'(rsp_valid), 32'(e4));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_err", 32'(rsp_err), (e.md == HANG) ? 1 : 0);
                    if (e.md == HANG) begin
                        chk("tmo_lat", cyc - e.ack, 15);
                        chk("tmo_start", 32'(spi_start), 0);
                    end else begin
                        chk("rsp_lat", cyc - nd_cyc, 1);
                        if (e.md == FAST) chk("fast_lat", cyc - e.ack, 2);
                    end
                end
            end
            if (m_busy) begin
                e4 = ~(4'b0001 << cur);
                chk("ss_o", 32'(ss_o), 32'(e4));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_data = '0; mode = NORM; sticky = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_rdata", 32'(rsp_data), 0);
        chk("rst_start", 32'(spi_start), 0);
        chk("rst_din", 32'(spi_data_in), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_ss", 32'(ss_o), 32'hF);
        chk("rst_owner", 32'(owner), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Contention: all four held, fresh pointer -> 0,1,2,3; then 0,1 again.
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'((i + 1) << 12);
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) gnt_q.push_back(i);
        drain(400);
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        gnt_q.push_back(0); gnt_q.push_back(1);
        drain(200);

        // Single transfer on requester 2.
        req_data[2*DW +: DW] = 16'hA5C3;
        req_valid[2] = 1'b1;
        gnt_q.push_back(2);
        @(negedge clk);
        chk("t1_ack", 32'(req_ack), 32'h4);
        chk("t1_start", 32'(spi_start), 1);
        chk("t1_active", 32'(active), 1);
        drain(100);

        // Fairness: req0 sticky, req3 raised once during req0's transfer.
        sticky[0] = 1'b1;
        req_data[0*DW +: DW] = 16'h0F0F;
        req_data[3*DW +: DW] = 16'h3C3C;
        req_valid[0] = 1'b1;
        gnt_q.push_back(0);
        wait_ack(0, 20);
        req_valid[3] = 1'b1;
        gnt_q.push_back(3); gnt_q.push_back(0);
        wait_ack(3, 60);
        sticky[0] = 1'b0;
        drain(200);

        // Timeout on a hung engine, then a normal transfer.
        mode = HANG;
        req_data[1*DW +: DW] = 16'hBEEF;
        req_valid[1] = 1'b1;
        gnt_q.push_back(1);
        drain(100);
        mode = NORM;
        req_data[2*DW +: DW] = 16'h5A5A;
        req_valid[2] = 1'b1;
        gnt_q.push_back(2);
        drain(100);

        // Fast engine: busy and new_data together.
        mode = FAST;
        req_data[0*DW +: DW] = 16'h00FF;
        req_valid[0] = 1'b1;
        gnt_q.push_back(0);
        drain(100);
        mode = NORM;

        // Reset during WAIT_DONE.
        req_data[1*DW +: DW] = 16'h1234;
        req_valid[1] = 1'b1;
        gnt_q.push_back(1);
        wait_ack(1, 20);
        repeat (4) @(negedge clk);
        chk("t6_busy", 32'(spi_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_active", 32'(active), 0);
        chk("t6_ss", 32'(ss_o), 32'hF);
        chk("t6_start", 32'(spi_start), 0);
        chk("t6_rsp", 32'(rsp_valid), 0);
        rsp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        req_data[0*DW +: DW] = 16'hC001;
        req_data[1*DW +: DW] = 16'hC002;
        req_data[3*DW +: DW] = 16'hC004;
        req_valid = 4'b1011;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(3);
        drain(200);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
